// File: rtl/mem_pkg.sv
// Shared encodings for the load/store initiator: access sizes, FSM states,
// the latched request record and the alignment rule.
package mem_pkg;

  localparam int STROBE_PERIOD_DEF = 10;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_DONE
  } state_t;

  // Only the low address bits are needed after accept; the word index is
  // registered straight onto the memory address bus.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic [1:0] lane;
    logic [31:0] wdata;
  } req_t;

  // Reserved size, odd half, or word not on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = a[0];
      SZ_WORD: is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lane_merge.sv
// Combinational lane handling: pulls a byte/half out of a memory word and
// extends it for loads, and splices store data into a word for read-modify-write.
module lane_merge
  import mem_pkg::*;
(
  input  logic [31:0] rword,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lane select; lane 0 is bits [7:0].
  always_comb begin
    byte_sel = rword[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? rword[31:16] : rword[15:0];
  end

  // Zero- or sign-extend the selected lane to a full word.
  always_comb begin
    case (size)
      SZ_BYTE: load_data = uns ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = uns ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_data = rword;
    endcase
  end

  // Overwrite only the addressed lane, keep the rest of the read word.
  always_comb begin
    merged = rword;
    case (size)
      SZ_BYTE: merged[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator: turns one byte-addressed CPU access into word
// commands held for a full strobe window, since the memory only acts on one
// unknown cycle per STROBE_PERIOD. Sub-word stores go read-modify-write.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int STROBE_PERIOD = STROBE_PERIOD_DEF,
  parameter int ADDR_W        = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_unsigned,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_misaligned,
  output logic              memWrite,
  output logic              memRead,
  output logic [31:0]       address,
  output logic [31:0]       writeData,
  input  logic [31:0]       readData
);

  localparam int CNT_W = (STROBE_PERIOD > 1) ? $clog2(STROBE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_PERIOD - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  req_t             req;
  logic [31:0]      load_data;
  logic [31:0]      merged;

  lane_merge u_lane (
    .rword     (readData),
    .lane      (req.lane),
    .size      (req.size),
    .uns       (req.uns),
    .wdata     (req.wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  // Sequencer: accept, hold each command for exactly STROBE_PERIOD cycles,
  // capture one settle cycle later, then pulse done.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      req            <= '0;
      cpu_busy       <= 1'b0;
      cpu_done       <= 1'b0;
      cpu_rdata      <= '0;
      cpu_misaligned <= 1'b0;
      memWrite       <= 1'b0;
      memRead        <= 1'b0;
      address        <= '0;
      writeData      <= '0;
    end else begin
      cpu_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            req.we    <= cpu_we;
            req.size  <= cpu_size;
            req.uns   <= cpu_unsigned;
            req.lane  <= cpu_addr[1:0];
            req.wdata <= cpu_wdata;
            cpu_busy  <= 1'b1;
            cnt       <= '0;
            if (is_misaligned(cpu_size, cpu_addr[1:0])) begin
              // Rejected: no memory command, load result left untouched.
              cpu_misaligned <= 1'b1;
              cpu_done       <= 1'b1;
              state          <= ST_DONE;
            end else begin
              cpu_misaligned <= 1'b0;
              address        <= 32'(cpu_addr >> 2);
              if (cpu_we && cpu_size == SZ_WORD) begin
                writeData <= cpu_wdata;
                memWrite  <= 1'b1;
                state     <= ST_WR;
              end else begin
                // Loads and sub-word stores both start with a read.
                memRead <= 1'b1;
                state   <= ST_RD;
              end
            end
          end
        end
        ST_RD: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            memRead <= 1'b0;
            state   <= ST_CAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CAP: begin
          // The strobe may have hit the last RD edge; readData is stable now.
          if (!req.we) begin
            cpu_rdata <= load_data;
            cpu_done  <= 1'b1;
            state     <= ST_DONE;
          end else begin
            writeData <= merged;
            memWrite  <= 1'b1;
            state     <= ST_WR;
          end
        end
        ST_WR: begin
          if (cnt == CNT_LAST) begin
            cnt      <= '0;
            memWrite <= 1'b0;
            cpu_done <= 1'b1;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          cpu_busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          cpu_busy <= 1'b0;
          memRead  <= 1'b0;
          memWrite <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: mem_access_unit against a strobed word memory whose strobe
// phase is swept over every offset, plus asynchronous reset mid-store.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int SP = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [1:0]  cpu_size = 2'b00;
  logic        cpu_unsigned = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_busy, cpu_done, cpu_misaligned, memWrite, memRead;
  logic [31:0] cpu_rdata, address, writeData;
  logic [31:0] readData;

  always #5 clock = ~clock;

  mem_access_unit #(.STROBE_PERIOD(SP), .ADDR_W(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_size       (cpu_size),
    .cpu_unsigned   (cpu_unsigned),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_busy       (cpu_busy),
    .cpu_done       (cpu_done),
    .cpu_rdata      (cpu_rdata),
    .cpu_misaligned (cpu_misaligned),
    .memWrite       (memWrite),
    .memRead        (memRead),
    .address        (address),
    .writeData      (writeData),
    .readData       (readData)
  );

  // Strobed memory: acts on one edge per SP cycles, phase set by the bench.
  int cyc = 0;
  int phase = 0;
  logic strobe;
  logic [31:0] mem [0:63];
  assign strobe = ((cyc + phase) % SP) == 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    if (!reset) readData <= '0;
    else if (strobe) begin
      if (memWrite) mem[address[5:0]] <= writeData;
      if (memRead)  readData <= mem[address[5:0]];
    end
  end

  int tests = 0;
  int fails = 0;
  int lat, nrd, nwr, extra;
  logic mis, both;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s p%0d: observed %h expected %h", tag, phase, obs, exp);
    end
  endtask

  // mode 0: plain op; 1: hammer req/addr while busy; 2: drop reset at cycle 5.
  task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input int mode);
    @(negedge clock);
    cpu_req = 1'b1; cpu_we = we; cpu_size = sz; cpu_unsigned = uns;
    cpu_addr = a; cpu_wdata = wd;
    @(posedge clock);
    #1 cpu_req = 1'b0;
    lat = -1; nrd = 0; nwr = 0; both = 1'b0; mis = 1'b0; extra = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (memRead)  nrd++;
      if (memWrite) nwr++;
      if (memRead && memWrite) both = 1'b1;
      if (mode == 2 && n == 5) begin
        chk("rst_pre_memWrite", {31'b0, memWrite}, 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_memWrite", {31'b0, memWrite}, 32'd0);
        chk("rst_flags", {27'b0, cpu_busy, cpu_done, cpu_misaligned, memRead, memWrite}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_writeData", writeData, 32'd0);
        return;
      end
      if (mode == 1 && n == 3) begin
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_size = SZ_WORD; cpu_addr = 32'h20; cpu_wdata = 32'h0;
      end
      if (mode == 1 && n == 4) begin
        cpu_req = 1'b0; cpu_addr = 32'h24;
      end
      if (cpu_done) begin
        lat = n; mis = cpu_misaligned;
        break;
      end
    end
    // After the pulse: done must drop and the unit go idle, with no queued op.
    for (int m = 1; m <= ((mode == 1) ? 25 : 2); m++) begin
      @(negedge clock);
      if (cpu_done) extra++;
      if (m == 1) chk("post_done_idle", {30'b0, cpu_done, cpu_busy}, 32'd0);
    end
    chk("extra_done", extra, 0);
  endtask

  task automatic op(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] wd, input int mode,
                    input int e_lat, input int e_rd, input int e_wr, input logic e_mis);
    do_op(we, sz, uns, a, wd, mode);
    chk({tag, "_lat"}, lat, e_lat);
    chk({tag, "_rd"}, nrd, e_rd);
    chk({tag, "_wr"}, nwr, e_wr);
    chk({tag, "_mis"}, {31'b0, mis}, {31'b0, e_mis});
    chk({tag, "_excl"}, {31'b0, both}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("reset_flags", {27'b0, cpu_busy, cpu_done, cpu_misaligned, memRead, memWrite}, 32'd0);
    chk("reset_rdata", cpu_rdata, 32'd0);
    chk("reset_address", address, 32'd0);
    chk("reset_writeData", writeData, 32'd0);
    #($urandom_range(1, 7)) reset = 1'b1;

    for (int p = 0; p < SP; p++) begin
      phase = p;
      // 1: word store then word load
      op("sw08", 1'b1, SZ_WORD, 1'b0, 32'h08, 32'hDEADBEEF, 0, 11, 0, 10, 1'b0);
      op("lw08", 1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, 0, 12, 10, 0, 1'b0);
      chk("lw08_data", cpu_rdata, 32'hDEADBEEF);
      // 2: byte read-modify-write into lane 1
      op("sw10", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344, 0, 11, 0, 10, 1'b0);
      op("sb11", 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h000000AA, 0, 22, 10, 10, 1'b0);
      op("lw10", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 0, 12, 10, 0, 1'b0);
      chk("lw10_data", cpu_rdata, 32'h1122AA44);
      // 3: extension of byte and half lanes
      op("sw20", 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h0000F080, 0, 11, 0, 10, 1'b0);
      op("lb20", 1'b0, SZ_BYTE, 1'b0, 32'h20, 32'h0, 0, 12, 10, 0, 1'b0);
      chk("lb20_data", cpu_rdata, 32'hFFFFFF80);
      op("lbu20", 1'b0, SZ_BYTE, 1'b1, 32'h20, 32'h0, 0, 12, 10, 0, 1'b0);
      chk("lbu20_data", cpu_rdata, 32'h00000080);
      op("lh20", 1'b0, SZ_HALF, 1'b0, 32'h20, 32'h0, 0, 12, 10, 0, 1'b0);
      chk("lh20_data", cpu_rdata, 32'hFFFFF080);
      op("lbu13", 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 0, 12, 10, 0, 1'b0);
      chk("lbu13_data", cpu_rdata, 32'h00000011);
      op("lh12", 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 0, 12, 10, 0, 1'b0);
      chk("lh12_data", cpu_rdata, 32'h00001122);
      op("lhu20", 1'b0, SZ_HALF, 1'b1, 32'h20, 32'h0, 0, 12, 10, 0, 1'b0);
      chk("lhu20_data", cpu_rdata, 32'h0000F080);
      // 4: rejects leave the load result alone
      op("lw06", 1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0, 0, 1, 0, 0, 1'b1);
      op("lh03", 1'b0, SZ_HALF, 1'b0, 32'h03, 32'h0, 0, 1, 0, 0, 1'b1);
      op("rsvd", 1'b1, SZ_RSVD, 1'b0, 32'h00, 32'h5, 0, 1, 0, 0, 1'b1);
      chk("reject_rdata", cpu_rdata, 32'h0000F080);
      // 5: requests and address changes while busy are ignored
      op("lw10_busy", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1, 12, 10, 0, 1'b0);
      chk("lw10_busy_data", cpu_rdata, 32'h1122AA44);
      op("lw20_after", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 0, 12, 10, 0, 1'b0);
      chk("lw20_after_data", cpu_rdata, 32'h0000F080);
      // 6: reset mid-store, then a normal load
      do_op(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h12345678, 2);
      repeat (2) @(negedge clock);
      #($urandom_range(1, 4)) reset = 1'b1;
      op("lw08_rst", 1'b0, SZ_WORD, 1'b0, 32'h08, 32'h0, 0, 12, 10, 0, 1'b0);
      chk("lw08_rst_data", cpu_rdata, 32'hDEADBEEF);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
